bp_dma_2to1_arbiter: RTL and testbench

- Shares one bsg_cache DMA port on the DRAM controller (pkt / read-data / write-data channels) between two requesters: requester 0 is the core's L2 DMA, requester 1 is a secondary bulk-loader or debug DMA.
- Arbitrates packets round-robin.
- Records the order in which packets are accepted, so read beats go back to the correct requester and write beats are drawn from the correct requester.
- Sits between the requesters and mig_ddr3_ram, in the core clock domain.

---
 rtl/bp_dma_2to1_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bp_dma_2to1_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_dma_2to1_arbiter.sv
// bp_dma_2to1_arbiter
// Shares one bsg_cache-style DMA port (pkt / read data / write data) between
// two requesters. Packets are arbitrated round-robin; the accepted order is
// recorded per direction so read beats return to, and write beats are pulled
// from, the requester that owns the block currently in flight.

// Small FIFO of requester ids, one per accepted packet in one direction.
module bp_dma_order_fifo #(
    parameter int els_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic data_o,
    output logic empty_o,
    output logic full_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [els_p-1:0]    mem_q, mem_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;

    assign data_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == cnt_w_lp'(els_p));

    // Next-state for storage, pointers (with explicit wrap) and occupancy.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) begin
            mem_d[wptr_q] = data_i;
            wptr_d = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
        end
        if (pop_i) begin
            rptr_d = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Register the FIFO state; reset empties it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module bp_dma_2to1_arbiter #(
    parameter  int addr_width_p      = 28,
    parameter  int data_width_p      = 64,
    parameter  int beats_per_block_p = 8,
    parameter  int order_els_p       = 4,
    localparam int pkt_width_lp      = 1 + addr_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [1:0][pkt_width_lp-1:0]     req_dma_pkt_i,
    input  logic [1:0]                       req_dma_pkt_v_i,
    output logic [1:0]                       req_dma_pkt_yumi_o,
    output logic [data_width_p-1:0]          req_dma_data_o,
    output logic [1:0]                       req_dma_data_v_o,
    input  logic [1:0]                       req_dma_data_ready_and_i,
    input  logic [1:0][data_width_p-1:0]     req_dma_data_i,
    input  logic [1:0]                       req_dma_data_v_i,
    output logic [1:0]                       req_dma_data_yumi_o,
    output logic [pkt_width_lp-1:0]          dma_pkt_o,
    output logic                             dma_pkt_v_o,
    input  logic                             dma_pkt_yumi_i,
    input  logic [data_width_p-1:0]          dma_data_i,
    input  logic                             dma_data_v_i,
    output logic                             dma_data_ready_and_o,
    output logic [data_width_p-1:0]          dma_data_o,
    output logic                             dma_data_v_o,
    input  logic                             dma_data_yumi_i,
    output logic                             error_o
);
    localparam int cnt_w_lp = $clog2(beats_per_block_p);
    localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_per_block_p - 1);

    logic                lock_q, lock_d;
    logic                grant_q, grant_d;
    logic                prio_q, prio_d;
    logic                error_q, error_d;
    logic [cnt_w_lp-1:0] rd_cnt_q, rd_cnt_d;
    logic [cnt_w_lp-1:0] wr_cnt_q, wr_cnt_d;

    logic       rd_push, rd_pop, rd_head, rd_empty, rd_full;
    logic       wr_push, wr_pop, wr_head, wr_empty, wr_full;
    logic [1:0] elig;
    logic       grant, pkt_hs, rd_hs, wr_hs;

    bp_dma_order_fifo #(.els_p(order_els_p)) rd_order (
        .clk_i(clk_i), .reset_i(reset_i),
        .push_i(rd_push), .data_i(grant), .pop_i(rd_pop),
        .data_o(rd_head), .empty_o(rd_empty), .full_o(rd_full)
    );

    bp_dma_order_fifo #(.els_p(order_els_p)) wr_order (
        .clk_i(clk_i), .reset_i(reset_i),
        .push_i(wr_push), .data_i(grant), .pop_i(wr_pop),
        .data_o(wr_head), .empty_o(wr_empty), .full_o(wr_full)
    );

    // Packet arbitration: held grant while locked, else round-robin among
    // requesters whose target order FIFO has room (registered full flag only).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_dma_pkt_v_i[i] & ~reset_i
                    & ~(req_dma_pkt_i[i][addr_width_p] ? wr_full : rd_full);
        end
        if (lock_q)       grant = grant_q;
        else if (elig[0]) grant = elig[1] ? prio_q : 1'b0;
        else              grant = 1'b1;
        dma_pkt_o   = req_dma_pkt_i[grant];
        dma_pkt_v_o = ~reset_i & (lock_q | (|elig));
        pkt_hs      = dma_pkt_v_o & dma_pkt_yumi_i;
        req_dma_pkt_yumi_o[0] = pkt_hs & ~grant;
        req_dma_pkt_yumi_o[1] = pkt_hs &  grant;
        rd_push = pkt_hs & ~dma_pkt_o[addr_width_p];
        wr_push = pkt_hs &  dma_pkt_o[addr_width_p];
    end

    // Lock/priority update: lock on a stalled offer, rotate priority on accept.
    always_comb begin
        lock_d  = lock_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        if (pkt_hs) begin
            lock_d = 1'b0;
            prio_d = ~grant;
        end else if (dma_pkt_v_o) begin
            lock_d  = 1'b1;
            grant_d = grant;
        end
    end

    // Read path: route controller beats to the head of the read order FIFO.
    always_comb begin
        req_dma_data_o       = dma_data_i;
        dma_data_ready_and_o = ~reset_i & ~rd_empty & req_dma_data_ready_and_i[rd_head];
        req_dma_data_v_o[0]  = ~reset_i & dma_data_v_i & ~rd_empty & ~rd_head;
        req_dma_data_v_o[1]  = ~reset_i & dma_data_v_i & ~rd_empty &  rd_head;
        rd_hs   = dma_data_v_i & dma_data_ready_and_o;
        rd_pop  = rd_hs & (rd_cnt_q == last_beat_lp);
        rd_cnt_d = rd_cnt_q;
        if (rd_hs) rd_cnt_d = rd_pop ? '0 : rd_cnt_q + cnt_w_lp'(1);
        // A beat with nobody waiting for it is a controller protocol breach.
        error_d = error_q | (dma_data_v_i & rd_empty);
        error_o = error_q & ~reset_i;
    end

    // Write path: pull beats from the head of the write order FIFO.
    always_comb begin
        dma_data_o   = req_dma_data_i[wr_head];
        dma_data_v_o = ~reset_i & ~wr_empty & req_dma_data_v_i[wr_head];
        wr_hs        = dma_data_v_o & dma_data_yumi_i;
        req_dma_data_yumi_o[0] = wr_hs & ~wr_head;
        req_dma_data_yumi_o[1] = wr_hs &  wr_head;
        wr_pop   = wr_hs & (wr_cnt_q == last_beat_lp);
        wr_cnt_d = wr_cnt_q;
        if (wr_hs) wr_cnt_d = wr_pop ? '0 : wr_cnt_q + cnt_w_lp'(1);
    end

    // Control state registers; reset discards any in-flight transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_q   <= 1'b0;
            grant_q  <= 1'b0;
            prio_q   <= 1'b0;
            error_q  <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            prio_q   <= prio_d;
            error_q  <= error_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end
endmodule

// File: tb/tb_bp_dma_2to1_arbiter.sv
// Randomized bench: two requester models and a DRAM-controller model drive
// the arbiter; a monitor checks packets, read routing and write sourcing
// against queues of expected traffic built from acceptance order.
module tb_bp_dma_2to1_arbiter;
    localparam int AW    = 28;
    localparam int DW    = 64;
    localparam int BEATS = 8;
    localparam int ELS   = 4;
    localparam int PW    = AW + 1;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [1:0][PW-1:0]   req_dma_pkt_i;
    logic [1:0]           req_dma_pkt_v_i;
    logic [1:0]           req_dma_pkt_yumi_o;
    logic [DW-1:0]        req_dma_data_o;
    logic [1:0]           req_dma_data_v_o;
    logic [1:0]           req_dma_data_ready_and_i;
    logic [1:0][DW-1:0]   req_dma_data_i;
    logic [1:0]           req_dma_data_v_i;
    logic [1:0]           req_dma_data_yumi_o;
    logic [PW-1:0]        dma_pkt_o;
    logic                 dma_pkt_v_o;
    logic                 dma_pkt_yumi_i;
    logic [DW-1:0]        dma_data_i;
    logic                 dma_data_v_i;
    logic                 dma_data_ready_and_o;
    logic [DW-1:0]        dma_data_o;
    logic                 dma_data_v_o;
    logic                 dma_data_yumi_i;
    logic                 error_o;

    bp_dma_2to1_arbiter #(
        .addr_width_p(AW), .data_width_p(DW),
        .beats_per_block_p(BEATS), .order_els_p(ELS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_dma_pkt_i(req_dma_pkt_i), .req_dma_pkt_v_i(req_dma_pkt_v_i),
        .req_dma_pkt_yumi_o(req_dma_pkt_yumi_o),
        .req_dma_data_o(req_dma_data_o), .req_dma_data_v_o(req_dma_data_v_o),
        .req_dma_data_ready_and_i(req_dma_data_ready_and_i),
        .req_dma_data_i(req_dma_data_i), .req_dma_data_v_i(req_dma_data_v_i),
        .req_dma_data_yumi_o(req_dma_data_yumi_o),
        .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
        .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i),
        .dma_data_ready_and_o(dma_data_ready_and_o),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Traffic model: packets waiting at each requester, write beats each
    // requester owes, read beats the controller will return, and the
    // acceptance order per direction.
    logic [PW-1:0] pend[2][$];
    logic [DW-1:0] wbeat[2][$];
    logic [DW-1:0] exp_rd[2][$];
    logic [DW-1:0] ctrl_rd[$];
    bit            rd_ord[$];
    bit            wr_ord[$];
    bit            lk, lk_id, prio;
    int            rd_beat, wr_beat;
    bit            mon_en = 1'b0;
    int            seq = 0;
    int            gen_pct, yumi_pct, rdv_pct;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] onehot(input bit id);
        return id ? 128'd2 : 128'd1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            pend[i].delete(); wbeat[i].delete(); exp_rd[i].delete();
        end
        ctrl_rd.delete(); rd_ord.delete(); wr_ord.delete();
        lk = 0; lk_id = 0; prio = 0; rd_beat = 0; wr_beat = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pkt_v"},     128'(dma_pkt_v_o), 128'd0);
        chk({tag, "_pkt_yumi"},  128'(req_dma_pkt_yumi_o), 128'd0);
        chk({tag, "_rd_v"},      128'(req_dma_data_v_o), 128'd0);
        chk({tag, "_rd_ready"},  128'(dma_data_ready_and_o), 128'd0);
        chk({tag, "_wr_v"},      128'(dma_data_v_o), 128'd0);
        chk({tag, "_wr_yumi"},   128'(req_dma_data_yumi_o), 128'd0);
        chk({tag, "_error"},     128'(error_o), 128'd0);
    endtask

    // One cycle of requester + controller stimulus, driven at the falling edge.
    task automatic drive_cycle();
        logic [PW-1:0] p;
        @(negedge clk_i);
        for (int i = 0; i < 2; i++) begin
            if (pend[i].size() < 6 && $urandom_range(99) < gen_pct) begin
                p = '0;
                p[AW]        = 1'($urandom_range(1));
                p[AW-1]      = 1'(i);
                p[AW-2:0]    = (AW-1)'(seq);
                seq++;
                pend[i].push_back(p);
                if (p[AW])
                    for (int b = 0; b < BEATS; b++)
                        wbeat[i].push_back({8'(i), 24'(seq), 32'(b)});
            end
            req_dma_pkt_v_i[i]          = (pend[i].size() > 0);
            req_dma_pkt_i[i]            = (pend[i].size() > 0) ? pend[i][0] : '0;
            req_dma_data_v_i[i]         = (wbeat[i].size() > 0) && ($urandom_range(99) < 70);
            req_dma_data_i[i]           = (wbeat[i].size() > 0) ? wbeat[i][0] : '0;
            req_dma_data_ready_and_i[i] = ($urandom_range(99) < 75);
        end
        dma_data_v_i    = (ctrl_rd.size() > 0) && ($urandom_range(99) < rdv_pct);
        dma_data_i      = (ctrl_rd.size() > 0) ? ctrl_rd[0] : '0;
        dma_pkt_yumi_i  = 1'b0;
        dma_data_yumi_i = 1'b0;
        #1;
        dma_pkt_yumi_i  = dma_pkt_v_o && ($urandom_range(99) < yumi_pct);
        dma_data_yumi_i = dma_data_v_o && ($urandom_range(99) < 50);
    endtask

    // Monitor: compares what the DUT presents with the expected traffic and
    // retires handshakes that will occur on the next rising edge.
    always @(negedge clk_i) begin
        logic [1:0] el;
        bit         g, exp_v, acc;
        logic [PW-1:0] pk;
        logic [DW-1:0] d;
        #2;
        if (mon_en) begin
            // packet channel, evaluated on pre-edge occupancy
            for (int i = 0; i < 2; i++)
                el[i] = (pend[i].size() > 0) &&
                        ((pend[i][0][AW] ? wr_ord.size() : rd_ord.size()) < ELS);
            exp_v = lk || (el != 2'b00);
            g     = lk ? lk_id : ((el == 2'b11) ? prio : el[1]);
            chk("pkt_v", 128'(dma_pkt_v_o), 128'(exp_v));
            if (exp_v && dma_pkt_v_o && pend[g].size() > 0)
                chk("pkt", 128'(dma_pkt_o), 128'(pend[g][0]));
            acc = dma_pkt_v_o && dma_pkt_yumi_i;
            chk("pkt_yumi", 128'(req_dma_pkt_yumi_o), acc ? onehot(g) : 128'd0);
            chk("error", 128'(error_o), 128'd0);

            // read channel
            if (rd_ord.size() > 0) begin
                chk("rd_ready", 128'(dma_data_ready_and_o),
                    128'(req_dma_data_ready_and_i[rd_ord[0]]));
                chk("rd_v", 128'(req_dma_data_v_o), dma_data_v_i ? onehot(rd_ord[0]) : 128'd0);
                if (dma_data_v_i && dma_data_ready_and_o) begin
                    if (exp_rd[rd_ord[0]].size() > 0) begin
                        chk("rd_data", 128'(req_dma_data_o), 128'(exp_rd[rd_ord[0]][0]));
                        void'(exp_rd[rd_ord[0]].pop_front());
                    end
                    if (ctrl_rd.size() > 0) void'(ctrl_rd.pop_front());
                    rd_beat++;
                    if (rd_beat == BEATS) begin
                        rd_beat = 0;
                        void'(rd_ord.pop_front());
                    end
                end
            end else begin
                chk("rd_ready_idle", 128'(dma_data_ready_and_o), 128'd0);
                chk("rd_v_idle", 128'(req_dma_data_v_o), 128'd0);
            end

            // write channel
            if (wr_ord.size() > 0) begin
                chk("wr_v", 128'(dma_data_v_o), 128'(req_dma_data_v_i[wr_ord[0]]));
                if (dma_data_v_o && dma_data_yumi_i) begin
                    chk("wr_yumi", 128'(req_dma_data_yumi_o), onehot(wr_ord[0]));
                    if (wbeat[wr_ord[0]].size() > 0) begin
                        chk("wr_data", 128'(dma_data_o), 128'(wbeat[wr_ord[0]][0]));
                        void'(wbeat[wr_ord[0]].pop_front());
                    end
                    wr_beat++;
                    if (wr_beat == BEATS) begin
                        wr_beat = 0;
                        void'(wr_ord.pop_front());
                    end
                end else begin
                    chk("wr_yumi_hold", 128'(req_dma_data_yumi_o), 128'd0);
                end
            end else begin
                chk("wr_v_idle", 128'(dma_data_v_o), 128'd0);
                chk("wr_yumi_idle", 128'(req_dma_data_yumi_o), 128'd0);
            end

            // packet acceptance: record order and queue the read return
            if (acc && pend[g].size() > 0) begin
                pk = pend[g].pop_front();
                if (pk[AW]) wr_ord.push_back(g);
                else begin
                    rd_ord.push_back(g);
                    for (int b = 0; b < BEATS; b++) begin
                        d = {$urandom, $urandom};
                        ctrl_rd.push_back(d);
                        exp_rd[g].push_back(d);
                    end
                end
                prio = !g;
                lk   = 0;
            end else if (dma_pkt_v_o) begin
                lk    = 1;
                lk_id = g;
            end
        end
    end

    task automatic zero_inputs();
        req_dma_pkt_i = '0; req_dma_pkt_v_i = '0;
        req_dma_data_ready_and_i = '0; req_dma_data_i = '0; req_dma_data_v_i = '0;
        dma_pkt_yumi_i = 0; dma_data_i = '0; dma_data_v_i = 0; dma_data_yumi_i = 0;
    endtask

    task automatic run_phase(input int n, input int g_pct, input int y_pct, input int r_pct);
        gen_pct = g_pct; yumi_pct = y_pct; rdv_pct = r_pct;
        for (int c = 0; c < n; c++) drive_cycle();
    endtask

    initial begin
        clear_model();
        zero_inputs();
        reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        // outputs stay quiet under reset even with every input asserting
        @(negedge clk_i);
        req_dma_pkt_v_i = 2'b11; req_dma_data_v_i = 2'b11;
        req_dma_data_ready_and_i = 2'b11; dma_data_v_i = 1; dma_pkt_yumi_i = 1; dma_data_yumi_i = 1;
        #1;
        chk_reset_outputs("por");
        @(posedge clk_i);
        #1;
        zero_inputs();
        @(negedge clk_i);
        reset_i = 1'b0;
        mon_en  = 1'b1;

        run_phase(800, 40, 60, 70);
        run_phase(800, 80, 30, 15);   // slow read return fills the order FIFOs

        // reset in the middle of live traffic
        @(posedge clk_i);
        #1;
        mon_en  = 1'b0;
        reset_i = 1'b1;
        #1;
        chk_reset_outputs("mid");
        @(posedge clk_i);
        #1;
        chk_reset_outputs("mid_edge");
        zero_inputs();
        clear_model();
        @(negedge clk_i);
        reset_i = 1'b0;
        mon_en  = 1'b1;

        run_phase(800, 60, 50, 60);

        // stray read beat with no outstanding read
        @(posedge clk_i);
        #1;
        mon_en  = 1'b0;
        reset_i = 1'b1;
        zero_inputs();
        clear_model();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("pre_stray_error", 128'(error_o), 128'd0);
        dma_data_v_i = 1'b1;
        dma_data_i   = 64'hDEAD_BEEF;
        #1;
        chk("stray_ready", 128'(dma_data_ready_and_o), 128'd0);
        chk("stray_v", 128'(req_dma_data_v_o), 128'd0);
        @(negedge clk_i);
        dma_data_v_i = 1'b0;
        #1;
        chk("stray_error", 128'(error_o), 128'd1);
        repeat (5) @(negedge clk_i);
        chk("stray_error_sticky", 128'(error_o), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
